// File: rtl/calc_pkg.sv
// Package: calc_pkg
// Shared constants and types for the calculator result display stage.
//  - SEG_0..SEG_9 / SEG_BLANK : seven-segment patterns {g,f,e,d,c,b,a}, active-high
//  - digit_idx_t              : which display digit is currently strobed
//  - conv_state_t             : binary-to-BCD converter state
//  - seg_decode()             : BCD nibble to segment pattern
package calc_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        UNITS    = 2'd0,
        TENS     = 2'd1,
        HUNDREDS = 2'd2
    } digit_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    // Non-decimal nibbles cannot come out of the converter; they map to blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Module: bin2bcd_serial
// Serial double-dabble converter: 8-bit unsigned word to 3 BCD digits in 8 steps.
// Ports:
//  clk    in   system clock
//  rst_n  in   asynchronous active-low reset
//  ena    in   clock enable; low freezes state and step count
//  start  in   load word and begin converting (honoured only while idle)
//  word   in   8-bit value to convert
//  busy   out  conversion in progress (decoded from the state register)
//  done   out  high during the final step; the edge that ends it completes the conversion
//  bcd    out  {hundreds,tens,units}; valid while done is high
module bin2bcd_serial
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic [7:0]  word,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state_reg, state_next;
    logic [2:0]  step_reg, step_next;
    logic [19:0] shift_reg, shift_next;     // {bcd[11:0], bin[7:0]}
    logic [11:0] adjusted;
    logic [19:0] stepped;
    logic        unused_carry;

    // Add-3 correction on each BCD nibble before the shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adjust
            logic [3:0] nibble;
            assign nibble               = shift_reg[8 + 4*gi +: 4];
            assign adjusted[4*gi +: 4]  = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
        end
    endgenerate

    // The hundreds nibble never exceeds 2 for an 8-bit input, so the bit
    // shifted out of it is always zero.
    assign stepped      = {adjusted[10:0], shift_reg[7:0], 1'b0};
    assign unused_carry = adjusted[11];

    assign busy = (state_reg == CONV);
    assign done = (state_reg == CONV) && (step_reg == 3'd7);
    assign bcd  = stepped[19:8];

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    shift_next = {12'd0, word};
                    step_next  = 3'd0;
                    state_next = CONV;
                end
            end
            CONV: begin
                shift_next = stepped;
                step_next  = step_reg + 3'd1;
                if (step_reg == 3'd7) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            shift_reg <= 20'd0;
        end else if (ena) begin
            state_reg <= state_next;
            step_reg  <= step_next;
            shift_reg <= shift_next;
        end
    end

endmodule

// File: rtl/calc_result_display.sv
// Module: calc_result_display
// Result display stage of the calculator: accepts a valid-strobed 8-bit result,
// converts it to BCD and drives a multiplexed 3-digit common-cathode display.
// Ports:
//  clk           in   system clock
//  rst_n         in   asynchronous active-low reset
//  ena           in   global enable; low freezes all state
//  result_in     in   unsigned result word
//  result_valid  in   result_in valid this cycle (sampled when ena=1)
//  busy          out  conversion in progress
//  seg           out  segments {g,f,e,d,c,b,a}, active-high, registered
//  digit_sel     out  one-hot digit strobe {hundreds,tens,units}, registered
module calc_result_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV   = 1024,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] result_in,
    input  logic       result_valid,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] digit_sel
);

    localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    // Pending buffer
    logic [7:0]  pending_reg, pending_next;
    logic        pending_full_reg, pending_full_next;
    logic        start;
    logic [7:0]  start_word;

    // Converter interface and display digits
    logic        conv_done;
    logic [11:0] conv_bcd;
    logic [11:0] display_reg;

    // Refresh multiplexing
    logic [CW-1:0] refresh_cnt_reg, refresh_cnt_next;
    digit_idx_t    digit_idx_reg, digit_idx_next;
    logic [6:0]    digit_seg [3];
    logic [2:0]    digit_blank;
    logic [6:0]    seg_next;
    logic [2:0]    digit_sel_next;

    // A buffered word always takes priority over the live input, so the
    // ordering of results is preserved.
    assign start      = !busy && (pending_full_reg || result_valid);
    assign start_word = pending_full_reg ? pending_reg : result_in;

    always_comb begin
        pending_next      = pending_reg;
        pending_full_next = pending_full_reg;
        if (busy) begin
            if (result_valid) begin
                pending_next      = result_in;
                pending_full_next = 1'b1;
            end
        end else if (pending_full_reg) begin
            // Pending is consumed this edge; a simultaneous new word refills it.
            pending_full_next = result_valid;
            if (result_valid) begin
                pending_next = result_in;
            end
        end
    end

    bin2bcd_serial u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .word  (start_word),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Leading-zero blanking: units are always shown.
    assign digit_blank[0] = 1'b0;
    assign digit_blank[1] = BLANK_LEADING && (display_reg[11:8] == 4'd0) && (display_reg[7:4] == 4'd0);
    assign digit_blank[2] = BLANK_LEADING && (display_reg[11:8] == 4'd0);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_decode
            assign digit_seg[gi] = digit_blank[gi] ? SEG_BLANK : seg_decode(display_reg[4*gi +: 4]);
        end
    endgenerate

    always_comb begin
        refresh_cnt_next = refresh_cnt_reg + CW'(1);
        digit_idx_next   = digit_idx_reg;
        if (refresh_cnt_reg == CNT_MAX) begin
            refresh_cnt_next = '0;
            case (digit_idx_reg)
                UNITS:   digit_idx_next = TENS;
                TENS:    digit_idx_next = HUNDREDS;
                default: digit_idx_next = UNITS;
            endcase
        end
    end

    always_comb begin
        seg_next       = SEG_BLANK;
        digit_sel_next = 3'b001;
        case (digit_idx_reg)
            UNITS: begin
                seg_next       = digit_seg[0];
                digit_sel_next = 3'b001;
            end
            TENS: begin
                seg_next       = digit_seg[1];
                digit_sel_next = 3'b010;
            end
            HUNDREDS: begin
                seg_next       = digit_seg[2];
                digit_sel_next = 3'b100;
            end
            default: begin
                seg_next       = SEG_BLANK;
                digit_sel_next = 3'b001;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg      <= 8'd0;
            pending_full_reg <= 1'b0;
            display_reg      <= 12'd0;
            refresh_cnt_reg  <= '0;
            digit_idx_reg    <= UNITS;
            seg              <= SEG_BLANK;
            digit_sel        <= 3'b001;
        end else if (ena) begin
            pending_reg      <= pending_next;
            pending_full_reg <= pending_full_next;
            // Digits change only on the completing edge, never mid-conversion.
            if (conv_done) begin
                display_reg <= conv_bcd;
            end
            refresh_cnt_reg  <= refresh_cnt_next;
            digit_idx_reg    <= digit_idx_next;
            seg              <= seg_next;
            digit_sel        <= digit_sel_next;
        end
    end

endmodule

// File: tb/tb_calc_result_display.sv
`timescale 1ns/1ps
module tb_calc_result_display;

    localparam int RD = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] result_in = 8'd0;
    logic       result_valid = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic [2:0] digit_sel;

    int tests = 0;
    int fails = 0;
    int shown = 0;   // value the model believes is on the display

    calc_result_display #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .result_in    (result_in),
        .result_valid (result_valid),
        .busy         (busy),
        .seg          (seg),
        .digit_sel    (digit_sel)
    );

    always #5 clk = ~clk;

    // Reference: what a 3-digit display of 'value' shows on the strobed digit.
    function automatic logic [6:0] exp_seg(input int value, input logic [2:0] sel);
        int h, t, u;
        h = value / 100;
        t = (value / 10) % 10;
        u = value % 10;
        case (sel)
            3'b001:  return SEG_TAB[u];
            3'b010:  return (h == 0 && t == 0) ? 7'h00 : SEG_TAB[t];
            3'b100:  return (h == 0) ? 7'h00 : SEG_TAB[h];
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // One-cycle valid pulse; returns at the negedge after the sampling edge.
    task automatic send(input logic [7:0] v);
        result_in    = v;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic wait_idle(output int nbusy, output bit timeout);
        nbusy   = 0;
        timeout = 1'b0;
        while (busy === 1'b1) begin
            nbusy++;
            if (nbusy > 60) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Observe a full refresh rotation; records per-digit segments and
    // counts one-hot / order / dwell-time violations.
    task automatic scan_display(output logic [6:0] ou, output logic [6:0] ot,
                                output logic [6:0] oh, output int bad);
        logic [2:0] prev;
        int         run;
        bit         first;
        ou = 7'bx; ot = 7'bx; oh = 7'bx; bad = 0;
        @(negedge clk);
        prev  = digit_sel;
        run   = 0;
        first = 1'b1;
        for (int i = 0; i < 14; i++) begin
            case (digit_sel)
                3'b001:  ou = seg;
                3'b010:  ot = seg;
                3'b100:  oh = seg;
                default: bad++;
            endcase
            if (digit_sel === prev) begin
                run++;
            end else begin
                if (!first && run != RD) bad++;
                if (digit_sel !== {prev[1:0], prev[2]}) bad++;
                first = 1'b0;
                run   = 1;
            end
            prev = digit_sel;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; result_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || seg !== 7'h00 || digit_sel !== 3'b001) begin
            fails++;
            $display("FAIL reset_hold: busy=%b seg=%h sel=%b, want 0/00/001", busy, seg, digit_sel);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || seg !== 7'h00 || digit_sel !== 3'b001) begin
            fails++;
            $display("FAIL reset_release: busy=%b seg=%h sel=%b, want 0/00/001", busy, seg, digit_sel);
        end
        @(negedge clk);
        tests++;
        if (seg !== 7'h3F || digit_sel !== 3'b001) begin
            fails++;
            $display("FAIL reset_first_edge: seg=%h sel=%b, want 3f/001", seg, digit_sel);
        end
        shown = 0;
        $display("[TB] reset: checked reset and first-edge display");
    endtask

    task automatic test_basic();
        int nbusy; bit to; logic [6:0] ou, ot, oh; int bad;
        send(8'd30);
        wait_idle(nbusy, to);
        tests++;
        if (to || nbusy != 8) begin
            fails++;
            $display("FAIL basic_busy: busy cycles=%0d timeout=%b, want 8", nbusy, to);
        end
        scan_display(ou, ot, oh, bad);
        tests++;
        if (ou !== 7'h3F || ot !== 7'h4F || oh !== 7'h00) begin
            fails++;
            $display("FAIL basic_digits: u=%h t=%h h=%h, want 3f/4f/00", ou, ot, oh);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL basic_rotation: %0d violations, want 0", bad);
        end
        shown = 30;
        $display("[TB] basic: value 30 busy=%0d u=%h t=%h h=%h", nbusy, ou, ot, oh);
    endtask

    task automatic test_random();
        int vals [7] = '{255, 0, 9, 10, 99, 100, 200};
        int v, nbusy, bad; bit to; logic [6:0] ou, ot, oh;
        for (int n = 0; n < 19; n++) begin
            v = (n < 7) ? vals[n] : int'($urandom_range(0, 255));
            send(8'(v));
            wait_idle(nbusy, to);
            tests++;
            if (to || nbusy != 8) begin
                fails++;
                $display("FAIL rand_busy v=%0d: busy cycles=%0d timeout=%b, want 8", v, nbusy, to);
            end
            scan_display(ou, ot, oh, bad);
            tests++;
            if (ou !== exp_seg(v, 3'b001) || ot !== exp_seg(v, 3'b010) || oh !== exp_seg(v, 3'b100)) begin
                fails++;
                $display("FAIL rand_digits v=%0d: u=%h t=%h h=%h, want %h/%h/%h", v, ou, ot, oh,
                         exp_seg(v, 3'b001), exp_seg(v, 3'b010), exp_seg(v, 3'b100));
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL rand_rotation v=%0d: %0d violations, want 0", v, bad);
            end
            shown = v;
            $display("[TB] random: value %0d u=%h t=%h h=%h", v, ou, ot, oh);
        end
    endtask

    // 12 accepted; 200 and 99 arrive while busy: 99 wins, 200 never shows.
    task automatic test_pending();
        int prev, exp_val; logic exp_busy;
        prev = shown;
        send(8'd12);
        for (int k = 0; k <= 26; k++) begin
            exp_busy = (k <= 7) || (k >= 9 && k <= 16);
            exp_val  = (k <= 8) ? prev : ((k <= 17) ? 12 : 99);
            tests++;
            if (busy !== exp_busy) begin
                fails++;
                $display("FAIL pending_busy k=%0d: busy=%b, want %b", k, busy, exp_busy);
            end
            tests++;
            if (seg !== exp_seg(exp_val, digit_sel)) begin
                fails++;
                $display("FAIL pending_seg k=%0d: seg=%h sel=%b, want %h (value %0d)", k, seg,
                         digit_sel, exp_seg(exp_val, digit_sel), exp_val);
            end
            result_valid = 1'b0;
            if (k == 2) begin result_in = 8'd200; result_valid = 1'b1; end
            if (k == 4) begin result_in = 8'd99;  result_valid = 1'b1; end
            @(negedge clk);
        end
        shown = 99;
        $display("[TB] pending: 12 then 99 displayed");
    endtask

    // ena low for 5 edges mid-conversion; valids during the freeze are ignored.
    task automatic test_ena_freeze();
        int prev, v, exp_val; logic exp_busy; logic [6:0] seg_snap; logic [2:0] sel_snap;
        prev = shown;
        v = int'($urandom_range(101, 255));
        send(8'(v));
        seg_snap = 7'h00; sel_snap = 3'b000;
        for (int k = 0; k <= 22; k++) begin
            exp_busy = (k <= 12);
            exp_val  = (k <= 13) ? prev : v;
            tests++;
            if (busy !== exp_busy) begin
                fails++;
                $display("FAIL ena_busy k=%0d: busy=%b, want %b", k, busy, exp_busy);
            end
            tests++;
            if (seg !== exp_seg(exp_val, digit_sel)) begin
                fails++;
                $display("FAIL ena_seg k=%0d: seg=%h sel=%b, want %h (value %0d)", k, seg,
                         digit_sel, exp_seg(exp_val, digit_sel), exp_val);
            end
            if (k == 2) begin
                seg_snap = seg;
                sel_snap = digit_sel;
            end
            if (k >= 3 && k <= 7) begin
                tests++;
                if (seg !== seg_snap || digit_sel !== sel_snap) begin
                    fails++;
                    $display("FAIL ena_hold k=%0d: seg=%h sel=%b, want %h/%b", k, seg, digit_sel,
                             seg_snap, sel_snap);
                end
            end
            if (k == 2) ena = 1'b0;
            if (k == 3) begin result_in = 8'd77; result_valid = 1'b1; end
            if (k == 7) begin result_valid = 1'b0; ena = 1'b1; end
            @(negedge clk);
        end
        shown = v;
        $display("[TB] ena_freeze: value %0d shown 5 cycles late", v);
    endtask

    // Reset at step 4 with a word pending: everything is dropped.
    task automatic test_reset_midconv();
        int v1, v2;
        v1 = int'($urandom_range(1, 255));
        v2 = int'($urandom_range(1, 255));
        send(8'(v1));
        result_in = 8'(v2); result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || seg !== 7'h00 || digit_sel !== 3'b001) begin
            fails++;
            $display("FAIL rst_mid_async: busy=%b seg=%h sel=%b, want 0/00/001", busy, seg, digit_sel);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || seg !== exp_seg(0, digit_sel)) begin
                fails++;
                $display("FAIL rst_mid_after j=%0d: busy=%b seg=%h sel=%b, want 0/%h", j, busy, seg,
                         digit_sel, exp_seg(0, digit_sel));
            end
        end
        shown = 0;
        $display("[TB] reset_midconv: dropped %0d and pending %0d", v1, v2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_pending();
        test_ena_freeze();
        test_reset_midconv();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
